// File: rtl/cordic_vectoring_iterative.sv
// Iterative vectoring-mode CORDIC: drives y to zero over six micro-rotations, returning scaled magnitude and angle.
// Optional macro CORDIC_QUADRANT_CORRECTION_EN pre-rotates left-half-plane inputs by +/-90 degrees at load.
module cordic_vectoring_iterative #(
    parameter int N_FRAC     = 7,
    parameter int GUARD_BITS = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic signed [N_FRAC:0]             x_i,
    input  logic signed [N_FRAC:0]             y_i,
    input  logic signed [N_FRAC:0]             z_i,
    input  logic                               data_in_valid_strobe_i,
    output logic signed [N_FRAC+GUARD_BITS:0]  x_o,
    output logic signed [N_FRAC+GUARD_BITS:0]  y_o,
    output logic signed [N_FRAC:0]             z_o,
    output logic                               busy_o,
    output logic                               data_out_valid_strobe_o
);
    localparam int W          = N_FRAC + 1 + GUARD_BITS;
    localparam int ZW         = N_FRAC + 1;
    localparam int ITERATIONS = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    // Angle in units of pi/128 for the micro-rotation with shift idx.
    function automatic logic [ZW-1:0] angle_f(input logic [2:0] idx);
        logic [ZW-1:0] a;
        case (idx)
            3'd0:    a = ZW'(32);
            3'd1:    a = ZW'(18);
            3'd2:    a = ZW'(9);
            3'd3:    a = ZW'(5);
            3'd4:    a = ZW'(2);
            3'd5:    a = ZW'(1);
            default: a = ZW'(0);
        endcase
        return a;
    endfunction

    state_t               state_r;
    logic [2:0]           cnt_r;
    logic signed [W-1:0]  x_r, y_r;
    logic [ZW-1:0]        z_r;
    logic signed [W-1:0]  x_res_r, y_res_r;
    logic [ZW-1:0]        z_res_r;
    logic                 busy_r;
    logic                 dv_r;

    logic signed [W-1:0]  x_ext_s, y_ext_s;
    logic signed [W-1:0]  x_ld_s, y_ld_s;
    logic [ZW-1:0]        z_ld_s;
    logic signed [W-1:0]  x_sh_s, y_sh_s;
    logic signed [W-1:0]  x_nxt_s, y_nxt_s;
    logic [ZW-1:0]        z_nxt_s;

    // Load path: sign-extend inputs and optionally fold the left half-plane into the right.
    always_comb begin
        x_ext_s = W'(x_i);
        y_ext_s = W'(y_i);
        x_ld_s  = x_ext_s;
        y_ld_s  = y_ext_s;
        z_ld_s  = z_i;
`ifdef CORDIC_QUADRANT_CORRECTION_EN
        if (x_ext_s[W-1]) begin
            if (!y_ext_s[W-1]) begin
                x_ld_s = y_ext_s;
                y_ld_s = -x_ext_s;
                z_ld_s = z_i + ZW'(64);
            end else begin
                x_ld_s = -y_ext_s;
                y_ld_s = x_ext_s;
                z_ld_s = z_i - ZW'(64);
            end
        end else begin
            x_ld_s = x_ext_s;
            y_ld_s = y_ext_s;
            z_ld_s = z_i;
        end
`endif
    end

    // One micro-rotation on the pre-iteration working values; y == 0 rotates as non-negative.
    always_comb begin
        x_sh_s = x_r >>> cnt_r;
        y_sh_s = y_r >>> cnt_r;
        if (!y_r[W-1]) begin
            x_nxt_s = x_r + y_sh_s;
            y_nxt_s = y_r - x_sh_s;
            z_nxt_s = z_r + angle_f(cnt_r);
        end else begin
            x_nxt_s = x_r - y_sh_s;
            y_nxt_s = y_r + x_sh_s;
            z_nxt_s = z_r - angle_f(cnt_r);
        end
    end

    // Control FSM, working datapath and registered results.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            x_res_r <= '0;
            y_res_r <= '0;
            z_res_r <= '0;
            busy_r  <= 1'b0;
            dv_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    dv_r <= 1'b0;
                    if (data_in_valid_strobe_i) begin
                        x_r     <= x_ld_s;
                        y_r     <= y_ld_s;
                        z_r     <= z_ld_s;
                        cnt_r   <= 3'd0;
                        busy_r  <= 1'b1;
                        state_r <= CALC;
                    end
                end
                CALC: begin
                    x_r <= x_nxt_s;
                    y_r <= y_nxt_s;
                    z_r <= z_nxt_s;
                    if (cnt_r == 3'(ITERATIONS - 1)) begin
                        x_res_r <= x_nxt_s;
                        y_res_r <= y_nxt_s;
                        z_res_r <= z_nxt_s;
                        dv_r    <= 1'b1;
                        state_r <= OUTPUT;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                OUTPUT: begin
                    dv_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    dv_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign x_o                     = x_res_r;
    assign y_o                     = y_res_r;
    assign z_o                     = z_res_r;
    assign busy_o                  = busy_r;
    assign data_out_valid_strobe_o = dv_r;
endmodule
